// File: rtl/eth_tx_ctrl.sv
// eth_tx_ctrl: RMII transmit framer. On an accepted start it sends preamble/SFD,
// destination/source MAC, length/type, payload popped from an FWFT byte FIFO,
// optional zero padding and the CRC-32 FCS as LSB-first dibits, then holds the
// line idle for the inter-frame gap.
// Build option: define ETH_TX_PAD_EN to pad short payloads with zero bytes up to
// 46 bytes; without it short payloads go straight to the FCS (runt frames).

module eth_tx_ctrl #(
   parameter logic [47:0] pDEST_MAC    = 48'hFFFF_FFFF_FFFF,
   parameter logic [47:0] pSRC_MAC     = 48'h0200_0000_0001,
   parameter logic [15:0] pLEN_TYPE    = 16'hFFFF,
   parameter int          pIFG_CYCLES  = 48,
   parameter int          pMAX_PAYLOAD = 1500
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Tx_Start,
   input  logic [10:0] Tx_Len,
   input  logic [7:0]  Data_Byte,
   input  logic        Data_Empty,
   output logic        Data_Rd,
   output logic        Tx_En,
   output logic [1:0]  Txd,
   output logic        Busy,
   output logic        Tx_Done,
   output logic        Tx_Err
);

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_DEST_ADDR,
      ST_SRC_ADDR,
      ST_LEN_TYPE,
      ST_PAYLOAD,
`ifdef ETH_TX_PAD_EN
      ST_PAD,
`endif
      ST_FCS,
      ST_IFG
   } state_t;

   localparam logic [15:0] IFG_LAST = 16'(pIFG_CYCLES - 1);

   state_t      state;
   state_t      state_nxt;
   logic [1:0]  dibit;
   logic [10:0] byte_cnt;
   logic [10:0] tx_len;
   logic [15:0] ifg_cnt;
   logic [31:0] crc;
   logic [31:0] fcs;
   logic [7:2]  cur_hi;
   logic [7:0]  byte_src;
   logic [1:0]  out_dibit;
   logic        frame_good;
   logic        tx_err_q;
   logic        start_ok;
   logic        last_dibit;
   logic        underrun;
   logic        load_byte;
   logic        keep_count;

   // Byte-parallel reflected CRC-32 (poly 0xEDB88320), one byte LSB first
   function automatic logic [31:0] crc_next(input logic [31:0] c_in, input logic [7:0] d);
      logic [31:0] c;
      c = c_in;
      for (int i = 0; i < 8; i++) begin
         if (c[0] ^ d[i])
            c = (c >> 1) ^ 32'hEDB8_8320;
         else
            c = c >> 1;
      end
      return c;
   endfunction

   assign start_ok   = (Tx_Len != 11'd0) && (Tx_Len <= 11'(pMAX_PAYLOAD));
   assign last_dibit = (dibit == 2'd3);
   assign fcs        = ~crc;
   assign Busy       = (state != ST_IDLE);
   assign Tx_Err     = tx_err_q;

   // The first dibit of a byte comes straight from its source (the FIFO head is
   // only valid in the pop cycle); the remaining three come from the latched copy
   assign out_dibit = (dibit == 2'd0) ? byte_src[1:0] :
                      (dibit == 2'd1) ? cur_hi[3:2]   :
                      (dibit == 2'd2) ? cur_hi[5:4]   : cur_hi[7:6];

   // Select the byte that the current field sends at position byte_cnt
   always_comb begin
      byte_src = 8'h00;
      case (state)
         ST_DEST_ADDR: begin
            case (byte_cnt[2:0])
               3'd0:    byte_src = pDEST_MAC[47:40];
               3'd1:    byte_src = pDEST_MAC[39:32];
               3'd2:    byte_src = pDEST_MAC[31:24];
               3'd3:    byte_src = pDEST_MAC[23:16];
               3'd4:    byte_src = pDEST_MAC[15:8];
               default: byte_src = pDEST_MAC[7:0];
            endcase
         end
         ST_SRC_ADDR: begin
            case (byte_cnt[2:0])
               3'd0:    byte_src = pSRC_MAC[47:40];
               3'd1:    byte_src = pSRC_MAC[39:32];
               3'd2:    byte_src = pSRC_MAC[31:24];
               3'd3:    byte_src = pSRC_MAC[23:16];
               3'd4:    byte_src = pSRC_MAC[15:8];
               default: byte_src = pSRC_MAC[7:0];
            endcase
         end
         ST_LEN_TYPE: byte_src = byte_cnt[0] ? pLEN_TYPE[7:0] : pLEN_TYPE[15:8];
         ST_PAYLOAD:  byte_src = Data_Byte;
         ST_FCS: begin
            case (byte_cnt[1:0])
               2'd0:    byte_src = fcs[7:0];
               2'd1:    byte_src = fcs[15:8];
               2'd2:    byte_src = fcs[23:16];
               default: byte_src = fcs[31:24];
            endcase
         end
         default:     byte_src = 8'h00;
      endcase
   end

   // State register
   always_ff @(posedge Clk) begin
      if (Rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Next-state decode and RMII/FIFO outputs
   always_comb begin
      state_nxt  = state;
      Tx_En      = 1'b0;
      Txd        = 2'b00;
      Data_Rd    = 1'b0;
      Tx_Done    = 1'b0;
      underrun   = 1'b0;
      load_byte  = 1'b0;
      keep_count = 1'b0;
      case (state)
         ST_IDLE: begin
            if (Tx_Start && start_ok)
               state_nxt = ST_PREAMBLE;
         end
         ST_PREAMBLE: begin
            Tx_En = 1'b1;
            Txd   = (last_dibit && byte_cnt == 11'd7) ? 2'b11 : 2'b01;
            if (last_dibit && byte_cnt == 11'd7)
               state_nxt = ST_DEST_ADDR;
         end
         ST_DEST_ADDR: begin
            Tx_En     = 1'b1;
            Txd       = out_dibit;
            load_byte = (dibit == 2'd0);
            if (last_dibit && byte_cnt == 11'd5)
               state_nxt = ST_SRC_ADDR;
         end
         ST_SRC_ADDR: begin
            Tx_En     = 1'b1;
            Txd       = out_dibit;
            load_byte = (dibit == 2'd0);
            if (last_dibit && byte_cnt == 11'd5)
               state_nxt = ST_LEN_TYPE;
         end
         ST_LEN_TYPE: begin
            Tx_En     = 1'b1;
            Txd       = out_dibit;
            load_byte = (dibit == 2'd0);
            if (last_dibit && byte_cnt == 11'd1)
               state_nxt = ST_PAYLOAD;
         end
         ST_PAYLOAD: begin
            if (dibit == 2'd0 && Data_Empty) begin
               underrun  = 1'b1;
               state_nxt = ST_IFG;
            end else begin
               Tx_En     = 1'b1;
               Txd       = out_dibit;
               Data_Rd   = (dibit == 2'd0);
               load_byte = (dibit == 2'd0);
               if (last_dibit && byte_cnt == tx_len - 11'd1) begin
`ifdef ETH_TX_PAD_EN
                  if (tx_len < 11'd46) begin
                     state_nxt  = ST_PAD;
                     keep_count = 1'b1;
                  end else begin
                     state_nxt  = ST_FCS;
                  end
`else
                  state_nxt = ST_FCS;
`endif
               end
            end
         end
`ifdef ETH_TX_PAD_EN
         ST_PAD: begin
            Tx_En     = 1'b1;
            Txd       = out_dibit;
            load_byte = (dibit == 2'd0);
            if (last_dibit && byte_cnt == 11'd45)
               state_nxt = ST_FCS;
         end
`endif
         ST_FCS: begin
            Tx_En     = 1'b1;
            Txd       = out_dibit;
            load_byte = (dibit == 2'd0);
            if (last_dibit && byte_cnt == 11'd3)
               state_nxt = ST_IFG;
         end
         ST_IFG: begin
            if (ifg_cnt == IFG_LAST) begin
               Tx_Done   = frame_good;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Counters, byte latch, CRC accumulation and status flags
   always_ff @(posedge Clk) begin
      if (Rst) begin
         dibit      <= 2'd0;
         byte_cnt   <= 11'd0;
         tx_len     <= 11'd0;
         ifg_cnt    <= 16'd0;
         crc        <= 32'hFFFF_FFFF;
         cur_hi     <= 6'd0;
         frame_good <= 1'b0;
         tx_err_q   <= 1'b0;
      end else begin
         tx_err_q <= 1'b0;
         dibit    <= Tx_En ? dibit + 2'd1 : 2'd0;

         if (state == ST_IDLE && Tx_Start) begin
            if (start_ok) begin
               tx_len     <= Tx_Len;
               crc        <= 32'hFFFF_FFFF;
               byte_cnt   <= 11'd0;
               frame_good <= 1'b0;
            end else begin
               tx_err_q   <= 1'b1;
            end
         end

         if (underrun)
            tx_err_q <= 1'b1;

         // FCS bytes are read out of the CRC, so it must stay frozen while they go out
         if (load_byte) begin
            cur_hi <= byte_src[7:2];
            if (state != ST_FCS)
               crc <= crc_next(crc, byte_src);
         end

         // Padding continues the payload byte count so it can stop at byte 45
         if (Tx_En && last_dibit) begin
            if (state_nxt != state && !keep_count)
               byte_cnt <= 11'd0;
            else
               byte_cnt <= byte_cnt + 11'd1;
         end

         // An underrun cycle already has the line idle, so it counts as the first gap cycle
         if (state == ST_IFG)
            ifg_cnt <= ifg_cnt + 16'd1;
         else if (underrun)
            ifg_cnt <= 16'd1;
         else
            ifg_cnt <= 16'd0;

         if (state == ST_FCS && state_nxt == ST_IFG)
            frame_good <= 1'b1;
      end
   end

endmodule

// File: tb/tb_eth_tx_ctrl.sv
// tb_eth_tx_ctrl: self-checking bench for eth_tx_ctrl. A queue models the FWFT
// payload FIFO, a scoreboard queue holds the frame bytes expected on the wire,
// and a negedge monitor collects dibits and strobe counts.

module tb_eth_tx_ctrl;

   localparam logic [47:0] cDEST = 48'hFFFF_FFFF_FFFF;
   localparam logic [47:0] cSRC  = 48'h0200_0000_0001;
   localparam logic [15:0] cLTYP = 16'hFFFF;
   localparam int          cIFG  = 48;
   localparam int          cMAX  = 1500;
`ifdef ETH_TX_PAD_EN
   localparam int          cLEN10_CYCLES = 288;
`else
   localparam int          cLEN10_CYCLES = 144;
`endif

   logic        Clk = 1'b0;
   logic        Rst;
   logic        Tx_Start;
   logic [10:0] Tx_Len;
   logic [7:0]  Data_Byte = 8'h00;
   logic        Data_Empty = 1'b1;
   logic        Data_Rd;
   logic        Tx_En;
   logic [1:0]  Txd;
   logic        Busy;
   logic        Tx_Done;
   logic        Tx_Err;

   int check_count = 0;
   int error_count = 0;

   logic [7:0] fifo_q[$];
   logic [7:0] sb_q[$];
   logic [1:0] dibit_q[$];

   int   en_cycles = 0, en_rises = 0, rd_cnt = 0, err_cnt = 0, done_cnt = 0;
   int   busy_cycles = 0, idle_cnt = 0, gap_at_done = 0, gap_at_busyfall = 0;
   int   txd_idle_bad = 0;
   logic en_prev = 1'b0, busy_prev = 1'b0;

   int   b_en, b_rises, b_rd, b_err, b_done, b_busy, d0;

   eth_tx_ctrl #(
      .pDEST_MAC   (cDEST),
      .pSRC_MAC    (cSRC),
      .pLEN_TYPE   (cLTYP),
      .pIFG_CYCLES (cIFG),
      .pMAX_PAYLOAD(cMAX)
   ) dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .Tx_Start  (Tx_Start),
      .Tx_Len    (Tx_Len),
      .Data_Byte (Data_Byte),
      .Data_Empty(Data_Empty),
      .Data_Rd   (Data_Rd),
      .Tx_En     (Tx_En),
      .Txd       (Txd),
      .Busy      (Busy),
      .Tx_Done   (Tx_Done),
      .Tx_Err    (Tx_Err)
   );

   always #5 Clk = ~Clk;

   // FWFT FIFO model: pop on Data_Rd, present the new head after the edge
   always @(posedge Clk) begin
      if (Data_Rd && fifo_q.size() > 0)
         void'(fifo_q.pop_front());
      Data_Empty <= (fifo_q.size() == 0);
      Data_Byte  <= (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
   end

   // Line monitor sampled mid-cycle
   always @(negedge Clk) begin : monitor
      int idle_n;
      if (Tx_En)
         idle_n = 0;
      else if (Busy)
         idle_n = idle_cnt + 1;
      else
         idle_n = idle_cnt;
      idle_cnt <= idle_n;
      if (Tx_En) begin
         dibit_q.push_back(Txd);
         en_cycles <= en_cycles + 1;
         if (!en_prev)
            en_rises <= en_rises + 1;
      end else if (Txd != 2'b00) begin
         txd_idle_bad <= txd_idle_bad + 1;
      end
      if (Busy)
         busy_cycles <= busy_cycles + 1;
      if (Data_Rd)
         rd_cnt <= rd_cnt + 1;
      if (Tx_Err)
         err_cnt <= err_cnt + 1;
      if (Tx_Done) begin
         done_cnt    <= done_cnt + 1;
         gap_at_done <= idle_n;
      end
      if (busy_prev && !Busy)
         gap_at_busyfall <= idle_n;
      en_prev   <= Tx_En;
      busy_prev <= Busy;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [31:0] crcByte(input logic [31:0] c_in, input logic [7:0] d);
      logic [31:0] c;
      c = c_in;
      for (int i = 0; i < 8; i++)
         c = (c[0] ^ d[i]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      return c;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      check_count++;
      if (got !== exp) begin
         error_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic pulseStart(input logic [10:0] len);
      Tx_Len   = len;
      Tx_Start = 1'b1;
      @(posedge Clk);
      #1;
      Tx_Start = 1'b0;
   endtask

   task automatic loadFifo(input int n, input logic [7:0] base);
      for (int i = 0; i < n; i++)
         fifo_q.push_back(base + 8'(i));
   endtask

   task automatic snapCounters();
      b_en    = en_cycles;
      b_rises = en_rises;
      b_rd    = rd_cnt;
      b_err   = err_cnt;
      b_done  = done_cnt;
      b_busy  = busy_cycles;
      d0      = dibit_q.size();
   endtask

   // Push the bytes the frame should carry, then request it
   task automatic applyStimulus(input logic [10:0] len);
      int avail;
      int n;
      avail = fifo_q.size();
      if (len >= 11'd1 && int'(len) <= cMAX) begin
         for (int i = 0; i < 6; i++) sb_q.push_back(cDEST[47-8*i -: 8]);
         for (int i = 0; i < 6; i++) sb_q.push_back(cSRC[47-8*i -: 8]);
         sb_q.push_back(cLTYP[15:8]);
         sb_q.push_back(cLTYP[7:0]);
         n = (int'(len) <= avail) ? int'(len) : avail;
         for (int i = 0; i < n; i++) sb_q.push_back(fifo_q[i]);
`ifdef ETH_TX_PAD_EN
         if (n == int'(len))
            for (int i = n; i < 46; i++) sb_q.push_back(8'h00);
`endif
      end
      pulseStart(len);
   endtask

   task automatic waitFrameEnd();
      int k;
      k = 0;
      while (Busy && k < 4000) begin
         @(posedge Clk);
         #1;
         k++;
      end
      checkOutput("frame_timeout", {31'd0, (k < 4000)}, 32'd1);
      waitCycles(4);
   endtask

   // Decode the captured frame and compare against the scoreboard
   task automatic checkFrame(input bit good);
      int n, nbytes, nchk, bad, k;
      logic [31:0] c;
      logic [7:0]  b, e;
      logic [1:0]  pe;
      n   = dibit_q.size() - d0;
      bad = 0;
      for (int i = 0; i < 32 && i < n; i++) begin
         pe = (i == 31) ? 2'b11 : 2'b01;
         if (dibit_q[d0+i] !== pe) bad++;
      end
      checkOutput("preamble_bad_dibits", 32'(bad), 32'd0);
      nbytes = (n > 32) ? (n - 32) / 4 : 0;
      nchk   = good ? nbytes - 4 : nbytes;
      if (nchk < 0) nchk = 0;
      c = 32'hFFFF_FFFF;
      for (int bi = 0; bi < nbytes; bi++) begin
         k = d0 + 32 + 4*bi;
         b = {dibit_q[k+3], dibit_q[k+2], dibit_q[k+1], dibit_q[k]};
         c = crcByte(c, b);
         if (bi < nchk) begin
            if (sb_q.size() == 0) begin
               checkOutput($sformatf("byte%0d_unexpected", bi), 32'd1, 32'd0);
            end else begin
               e = sb_q.pop_front();
               checkOutput($sformatf("byte%0d", bi), {24'd0, b}, {24'd0, e});
            end
         end
      end
      checkOutput("sb_remaining", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
      if (good)
         checkOutput("fcs_residue", c, 32'hDEBB_20E3);
   endtask

   initial begin
      Rst      = 1'b1;
      Tx_Start = 1'b0;
      Tx_Len   = 11'd0;
      waitCycles(3);
      checkOutput("reset_outputs", {25'd0, Tx_En, Txd, Busy, Data_Rd, Tx_Done, Tx_Err}, 32'd0);
      Rst = 1'b0;
      waitCycles(2);

      $display("[TB] frame Tx_Len=46");
      loadFifo(46, 8'h00);
      snapCounters();
      applyStimulus(11'd46);
      waitFrameEnd();
      checkFrame(1'b1);
      checkOutput("len46_en_cycles", 32'(en_cycles - b_en), 32'd288);
      checkOutput("len46_rd", 32'(rd_cnt - b_rd), 32'd46);
      checkOutput("len46_done", 32'(done_cnt - b_done), 32'd1);
      checkOutput("len46_err", 32'(err_cnt - b_err), 32'd0);
      checkOutput("len46_gap_to_done", 32'(gap_at_done), 32'(cIFG));

      $display("[TB] frame Tx_Len=10");
      loadFifo(10, 8'hA0);
      snapCounters();
      applyStimulus(11'd10);
      waitFrameEnd();
      checkFrame(1'b1);
      checkOutput("len10_en_cycles", 32'(en_cycles - b_en), 32'(cLEN10_CYCLES));
      checkOutput("len10_rd", 32'(rd_cnt - b_rd), 32'd10);
      checkOutput("len10_done", 32'(done_cnt - b_done), 32'd1);

      $display("[TB] underrun Tx_Len=100 with 20 bytes");
      loadFifo(20, 8'h10);
      snapCounters();
      applyStimulus(11'd100);
      waitFrameEnd();
      checkFrame(1'b0);
      checkOutput("underrun_en_cycles", 32'(en_cycles - b_en), 32'd168);
      checkOutput("underrun_rd", 32'(rd_cnt - b_rd), 32'd20);
      checkOutput("underrun_err", 32'(err_cnt - b_err), 32'd1);
      checkOutput("underrun_done", 32'(done_cnt - b_done), 32'd0);
      checkOutput("underrun_gap_to_idle", 32'(gap_at_busyfall), 32'(cIFG));

      $display("[TB] rejected lengths");
      snapCounters();
      applyStimulus(11'd0);
      waitCycles(4);
      checkOutput("len0_err", 32'(err_cnt - b_err), 32'd1);
      applyStimulus(11'd1501);
      waitCycles(4);
      checkOutput("len1501_err", 32'(err_cnt - b_err), 32'd2);
      checkOutput("rejected_busy_cycles", 32'(busy_cycles - b_busy), 32'd0);
      checkOutput("rejected_en_cycles", 32'(en_cycles - b_en), 32'd0);

      $display("[TB] second start during frame");
      loadFifo(60, 8'h40);
      snapCounters();
      applyStimulus(11'd46);
      waitCycles(48);
      pulseStart(11'd20);
      waitFrameEnd();
      waitCycles(20);
      checkFrame(1'b1);
      checkOutput("dup_start_frames", 32'(en_rises - b_rises), 32'd1);
      checkOutput("dup_start_rd", 32'(rd_cnt - b_rd), 32'd46);
      checkOutput("dup_start_en_cycles", 32'(en_cycles - b_en), 32'd288);
      checkOutput("dup_start_err", 32'(err_cnt - b_err), 32'd0);
      fifo_q.delete();
      waitCycles(2);

      $display("[TB] reset during payload");
      loadFifo(46, 8'h80);
      snapCounters();
      applyStimulus(11'd46);
      waitCycles(99);
      Rst = 1'b1;
      waitCycles(1);
      checkOutput("midframe_rst_outputs", {25'd0, Tx_En, Txd, Busy, Data_Rd, Tx_Done, Tx_Err}, 32'd0);
      Rst = 1'b0;
      sb_q.delete();
      fifo_q.delete();
      waitCycles(3);
      checkOutput("midframe_rst_done", 32'(done_cnt - b_done), 32'd0);

      loadFifo(46, 8'hC0);
      snapCounters();
      applyStimulus(11'd46);
      waitFrameEnd();
      checkFrame(1'b1);
      checkOutput("after_rst_en_cycles", 32'(en_cycles - b_en), 32'd288);
      checkOutput("after_rst_rd", 32'(rd_cnt - b_rd), 32'd46);
      checkOutput("after_rst_done", 32'(done_cnt - b_done), 32'd1);

      checkOutput("txd_nonzero_while_idle", 32'(txd_idle_bad), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end

endmodule
